// File: rtl/aes_spi_frame_slave.sv
// SPI-slave framing responder: receives plaintext, key size and key, launches
// the AES core, then shifts the 16-byte result back to the master (SPI mode 0).
module aes_spi_frame_slave #(
  parameter int KEY_MAX_BYTES = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cs,
  input  logic                       sclk,
  input  logic                       mosi,
  output logic                       miso,
  output logic [127:0]               text_out,
  output logic [KEY_MAX_BYTES*8-1:0] key_out,
  output logic [7:0]                 key_size_out,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic [127:0]               core_result,
  output logic                       byte_done,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int KW = KEY_MAX_BYTES * 8;
  localparam int IW = $clog2(KW);
  localparam logic [8:0] KMAX = 9'(KEY_MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, RX_TEXT, RX_SIZE, RX_KEY, WAIT_CORE, TX_RESULT, ERROR
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_q, cs_q;
  logic       s_sclk, s_cs, s_mosi;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, rx_byte, tx_shift;
  logic [127:0] tx_reg;
  logic [5:0] idx;
  logic       byte_complete, abort, size_ok, byte_ev;
  logic [IW-1:0] key_base;
  logic [6:0] text_base;

  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_cs      = cs_sync[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_q;
  assign sclk_fall = ~s_sclk & sclk_q;
  assign cs_rise   = s_cs & ~cs_q;
  assign cs_fall   = ~s_cs & cs_q;

  assign rx_byte       = {rx_shift[6:0], s_mosi};
  assign byte_complete = sclk_rise && (bit_cnt == 3'd7);
  assign abort         = cs_rise && (state != IDLE);
  assign size_ok       = ((rx_byte == 8'd16) || (rx_byte == 8'd24) || (rx_byte == 8'd32))
                         && ({1'b0, rx_byte} <= KMAX);
  // idx counts remaining key bytes, so byte k lands at (key_size-k-1)*8
  assign key_base  = IW'({idx - 6'd1, 3'b000});
  assign text_base = {idx[3:0], 3'b000};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= s_sclk;
      cs_q      <= s_cs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_ev    = 1'b0;
    if (state == IDLE) begin
      if (cs_fall) state_next = RX_TEXT;
    end else if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        RX_TEXT: if (byte_complete) begin
          byte_ev = 1'b1;
          if (idx == 6'd0) state_next = RX_SIZE;
        end
        RX_SIZE: if (byte_complete) begin
          byte_ev    = 1'b1;
          state_next = size_ok ? RX_KEY : ERROR;
        end
        RX_KEY: if (byte_complete) begin
          byte_ev = 1'b1;
          if (idx == 6'd1) state_next = WAIT_CORE;
        end
        WAIT_CORE: if (core_done) state_next = TX_RESULT;
        TX_RESULT: if (byte_complete) begin
          byte_ev = 1'b1;
          if (idx == 6'd0) state_next = IDLE;
        end
        ERROR:   ;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miso         <= 1'b0;
      text_out     <= '0;
      key_out      <= '0;
      key_size_out <= '0;
      core_start   <= 1'b0;
      byte_done    <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_reg       <= '0;
      idx          <= '0;
    end else begin
      core_start <= 1'b0;
      byte_done  <= byte_ev;
      if (cs_fall) frame_err <= 1'b0;
      if (abort) begin
        bit_cnt  <= '0;
        tx_shift <= '0;
        miso     <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (state != IDLE && sclk_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
        end
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            miso    <= 1'b0;
            idx     <= 6'd15;
          end
          RX_TEXT: begin
            if (sclk_rise) busy <= 1'b1;
            if (byte_complete) begin
              text_out[text_base +: 8] <= rx_byte;
              idx <= idx - 6'd1;
            end
          end
          RX_SIZE: if (byte_complete) begin
            if (size_ok) begin
              key_size_out <= rx_byte;
              key_out      <= '0;
              idx          <= rx_byte[5:0];
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
            end
          end
          RX_KEY: if (byte_complete) begin
            key_out[key_base +: 8] <= rx_byte;
            idx <= idx - 6'd1;
            if (idx == 6'd1) core_start <= 1'b1;
          end
          WAIT_CORE: begin
            miso <= 1'b0;
            if (core_done) begin
              // bit 127 goes out immediately; tx_shift holds the bits still to send
              tx_reg   <= {core_result[119:0], 8'h00};
              tx_shift <= {core_result[126:120], 1'b0};
              miso     <= core_result[127];
              idx      <= 6'd15;
              bit_cnt  <= '0;
            end
          end
          TX_RESULT: begin
            if (sclk_fall) begin
              miso     <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (byte_complete) begin
              idx      <= idx - 6'd1;
              tx_shift <= tx_reg[127:120];
              tx_reg   <= {tx_reg[119:0], 8'h00};
              if (idx == 6'd0) begin
                busy     <= 1'b0;
                miso     <= 1'b0;
                tx_shift <= '0;
              end
            end
          end
          ERROR:   miso <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
